// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial add/subtract controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width: ceil(log2(width)), never below 1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned CNT_W_DEFAULT = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_adder_mux.sv
// 1-bit full-adder cell; carry is selected by the propagate term.
module full_adder_mux (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate selects incoming carry, otherwise generate equals x (x == y).
  always_comb begin
    p  = x ^ y;
    s  = p ^ ci;
    co = p ? ci : x;
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one result bit per cycle through a single full-adder cell.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               c_q;
  logic [CNT_W-1:0]   cnt;
  logic               fa_s;
  logic               fa_co;

  full_adder_mux u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Control FSM and datapath registers; sum doubles as the result shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b ^ {WIDTH{sub}};
            c_q      <= sub;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          a_q <= a_q >> 1;
          b_q <= b_q >> 1;
          sum <= {fa_s, sum[WIDTH-1:1]};
          c_q <= fa_co;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            ovf       <= c_q ^ fa_co;
            cout      <= fa_co;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, overflow from operand/result signs.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    logic [W:0]   t;
    logic [W-1:0] bb;
    bb = ms ? ~mb : mb;
    t  = {1'b0, ma} + {1'b0, bb} + (W+1)'(ms);
    es = t[W-1:0];
    ec = t[W];
    if (ms) eo = (ma[W-1] != mb[W-1]) && (es[W-1] != ma[W-1]);
    else    eo = (ma[W-1] == mb[W-1]) && (es[W-1] != ma[W-1]);
  endtask

  // One full operation: accept, scrambled inputs during RUN, hold in DONE, then release.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                        input int hold, input string tag);
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    int           n;
    model(ta, tb, ts, es, ec, eo);
    a = ta; b = tb; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check({tag, ".busy_run"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(W));
    check({tag, ".sum"}, 32'(sum), 32'(es));
    check({tag, ".cout"}, 32'(cout), 32'(ec));
    check({tag, ".ovf"}, 32'(ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); sub = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
      check({tag, ".hold_res"}, {23'd0, ovf, cout, sum}, {23'd0, eo, ec, es});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check({tag, ".rel_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".rel_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".rel_busy"}, 32'(busy), 32'd0);
    check({tag, ".retain"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int  t1;
    int  t2;
    int  cyc;
    bit  seen;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.res", {23'd0, ovf, cout, sum}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Directed cases.
    run_op(8'h5A, 8'h3C, 1'b0, 0, "c1");
    run_op(8'hFF, 8'h01, 1'b0, 0, "c2");
    run_op(8'h0A, 8'h14, 1'b1, 0, "c3");
    run_op(8'h80, 8'h01, 1'b1, 0, "c4");
    run_op(8'h7F, 8'h01, 1'b0, 5, "bp");
    run_op(8'h33, 8'hC4, 1'b1, 0, "bp_next");

    // Reset in the middle of RUN.
    a = 8'hAB; b = 8'hCD; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("mrst.in_ready", 32'(in_ready), 32'd1);
    check("mrst.out_valid", 32'(out_valid), 32'd0);
    check("mrst.busy", 32'(busy), 32'd0);
    check("mrst.res", {23'd0, ovf, cout, sum}, 32'd0);
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    @(negedge clk); rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    check("mrst.no_result", 32'(seen), 32'd0);
    check("mrst.idle_busy", 32'(busy), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, 0, "post_rst");

    // Randomized operations with random backpressure.
    for (int k = 0; k < 16; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "rnd");

    // Throughput with out_ready tied high and requests always pending.
    out_ready = 1'b1; in_valid = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0;
    t1 = -1; t2 = -1; cyc = 0;
    while (t2 < 0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) begin
        if (t1 < 0) t1 = cyc;
        else        t2 = cyc;
      end
    end
    check("tput.period", 32'(t2 - t1), 32'(W + 2));
    check("tput.sum", 32'(sum), 32'h46);
    in_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 30) begin @(posedge clk); #1; cyc++; end
    check("tput.drain", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH shall default to 8; it sets the operand width in bits, legal range 2..32.
REQ-002 Port clk shall be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst shall be an input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port in_valid shall be an input, 1 bit: the requester presents an operation.
REQ-005 Port in_ready shall be an output, 1 bit: the controller can accept an operation.
REQ-006 Port a shall be an input, WIDTH bits: operand A, unsigned or two's complement.
REQ-007 Port b shall be an input, WIDTH bits: operand B.
REQ-008 Port sub shall be an input, 1 bit: 0 selects A+B, 1 selects A-B.
REQ-009 Port out_valid shall be an output, 1 bit: the result is available.
REQ-010 Port out_ready shall be an input, 1 bit: the consumer takes the result.
REQ-011 Port sum shall be an output, WIDTH bits: the result.
REQ-012 Port cout shall be an output, 1 bit: carry out of the MSB; for subtraction, 1 means no borrow.
REQ-013 Port ovf shall be an output, 1 bit: signed overflow, computed as carry into the MSB XOR carry out of the MSB.
REQ-014 Port busy shall be an output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 States shall be IDLE, RUN and DONE.
REQ-016 In IDLE, in_ready shall be 1; in every other state it shall be 0.
REQ-017 Acceptance shall occur on a rising edge with in_valid=1 and in_ready=1; on acceptance the controller latches a, latches (b XOR {WIDTH{sub}}), sets carry register = sub, clears the bit counter, and moves to RUN.
REQ-018 In RUN, each cycle shall present the LSBs of the A/B shift registers and the carry register to a single 1-bit full-adder cell.
  - On the edge: A/B shift right; the full-adder sum bit shifts into the MSB of the result register; the carry register takes the full-adder carry out; the counter increments.
REQ-019 On the RUN edge where counter = WIDTH-1:
  - ovf <= carry register XOR full-adder carry out; cout <= full-adder carry out.
  - The state moves to DONE.
  - out_valid shall first be 1 exactly WIDTH rising edges after the acceptance edge.
REQ-020 In DONE, out_valid shall be 1, and sum, cout and ovf shall hold stable until a rising edge with out_ready=1; that edge returns the state to IDLE with out_valid=0.
REQ-021 in_valid and operand changes outside the acceptance edge shall have no effect.
REQ-022 Throughput: one operation per WIDTH+2 cycles when out_ready is tied high.
REQ-023 sum, cout and ovf shall be meaningful only while out_valid=1; between operations they shall retain their last values.

Reset
REQ-024 While rst=1, the block shall asynchronously force:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0, busy = 0
  - sum = 0, cout = 0, ovf = 0
  - counter, carry register and shift registers = 0
REQ-025 Reset asserted during RUN or DONE shall abandon the operation and emit no result; the first acceptance is possible on the first rising edge after rst deasserts.

Structure
REQ-026 Package serial_add_pkg shall hold the state enumeration (IDLE, RUN, DONE) and the counter-width constant, defined as ceil(log2(WIDTH)).
REQ-027 The block shall instantiate exactly one 1-bit full-adder cell (the team's full_adder_mux) as its only arithmetic sub-module; there shall be no WIDTH-bit adder.

Verification (WIDTH=8)
REQ-028 Case 1: a=8'h5A, b=8'h3C, sub=0 shall give sum=8'h96, cout=0, ovf=1, with out_valid rising exactly 8 edges after acceptance.
REQ-029 Case 2: a=8'hFF, b=8'h01, sub=0 shall give sum=8'h00, cout=1, ovf=0.
REQ-030 Case 3: a=8'h0A, b=8'h14, sub=1 shall give sum=8'hF6, cout=0, ovf=0; Case 4: a=8'h80, b=8'h01, sub=1 shall give sum=8'h7F, cout=1, ovf=1.
REQ-031 Backpressure: with out_ready held 0 for 5 cycles in DONE, sum/cout/ovf shall stay stable, in_ready shall stay 0, and an in_valid pulse with new operands shall be ignored; out_ready=1 shall give IDLE on the next edge, and the next accept shall produce the correct new result.
REQ-032 Reset asserted after 3 RUN cycles shall immediately force the REQ-024 values, with no out_valid pulse afterwards; a following 8'h01+8'h01 shall give sum=8'h02.
